// File: rtl/smc_enc_req_queue.sv
// smc_enc_req_queue
//   Queues cache-line encryption requests for data accesses that the SMC bound
//   checker flags as hits, and hands them to the line encryption engine over a
//   valid/ready handshake. The CPU access is stalled while the queue is full.
//
//   Optional feature macro: SMC_LINE_MERGE_EN
//     When defined, an access to the same line as the most recently pushed
//     entry merges into that entry (we is ORed) instead of taking a new slot.
//
// Ports
//   clk, rst     core clock, synchronous active-high reset
//   acc_valid    CPU data access strobe
//   acc_we       access is a store
//   acc_addr     access address
//   hit          SMC check result for acc_addr (same cycle)
//   acc_stall    hold the current access; CPU re-presents it next cycle
//   req_valid    queue head valid
//   req_ready    encryption engine accepts the head
//   req_addr     line-aligned head address
//   req_we       head line contains at least one store
//   count        current occupancy
module smc_enc_req_queue #(
    parameter int DEPTH     = 4,
    parameter int LINE_BITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     acc_valid,
    input  logic                     acc_we,
    input  logic [31:0]              acc_addr,
    input  logic                     hit,
    output logic                     acc_stall,
    output logic                     req_valid,
    input  logic                     req_ready,
    output logic [31:0]              req_addr,
    output logic                     req_we,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = 32 - LINE_BITS;

    logic [DEPTH-1:0][TW-1:0] line_q;
    logic [DEPTH-1:0]         we_q;
    logic [PW-1:0]            wr_ptr, rd_ptr, tail_ptr;
    logic                     qual, full, pop, push, merge, line_hit;
    logic                     unused_lo;

    // Offset bits within a line never affect queueing.
    assign unused_lo = ^acc_addr[LINE_BITS-1:0];

    assign qual      = acc_valid & hit;
    assign full      = (count == CW'(DEPTH));
    assign req_valid = (count != '0);
    assign pop       = req_valid & req_ready;
    assign tail_ptr  = wr_ptr - PW'(1);

`ifdef SMC_LINE_MERGE_EN
    assign line_hit = (count != '0) & (acc_addr[31:LINE_BITS] == line_q[tail_ptr]);
    // If the only entry is leaving this cycle, the access becomes a new entry.
    assign merge    = qual & line_hit & ~((count == CW'(1)) & pop);
`else
    assign line_hit = 1'b0;
    assign merge    = 1'b0;
`endif

    // When full, count != 1 (DEPTH >= 2), so line_hit equals merge there; using
    // line_hit keeps req_ready out of the stall path.
    assign acc_stall = qual & full & ~line_hit;
    assign push      = qual & ~acc_stall & ~merge;

    // Outputs are gated so the idle bus reads as zero.
    assign req_addr = req_valid ? {line_q[rd_ptr], {LINE_BITS{1'b0}}} : 32'h0;
    assign req_we   = req_valid & we_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
            we_q   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                line_q[wr_ptr] <= acc_addr[31:LINE_BITS];
                we_q[wr_ptr]   <= acc_we;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (merge)
                we_q[tail_ptr] <= we_q[tail_ptr] | acc_we;
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_smc_enc_req_queue.sv
module tb_smc_enc_req_queue;
    localparam int DEPTH = 4;
    localparam int LB    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        acc_valid, acc_we, hit, req_ready;
    logic [31:0] acc_addr;
    logic        acc_stall, req_valid, req_we;
    logic [31:0] req_addr;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    // scoreboard entries: {line-aligned addr, we}
    logic [32:0] sb[$];

    smc_enc_req_queue #(.DEPTH(DEPTH), .LINE_BITS(LB)) dut (
        .clk(clk), .rst(rst), .acc_valid(acc_valid), .acc_we(acc_we),
        .acc_addr(acc_addr), .hit(hit), .acc_stall(acc_stall),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .count(count)
    );

    always #5 clk = ~clk;

    // Reference model, evaluated mid-cycle with inputs stable.
    always @(negedge clk) begin
        logic        qual, lhit, exp_stall, mrg, pp, psh;
        logic [32:0] head;
        int          n;
        n    = sb.size();
        qual = acc_valid && hit;
        lhit = 1'b0;
`ifdef SMC_LINE_MERGE_EN
        if (n > 0) lhit = (acc_addr[31:LB] == sb[n-1][32:LB+1]);
`endif
        exp_stall = qual && (n == DEPTH) && !lhit;
        pp        = (n > 0) && req_ready;
        mrg       = qual && lhit && !((n == 1) && pp);
        psh       = qual && !exp_stall && !mrg;

        checks++;
        if (count !== 3'(n)) begin
            errors++; $display("FAIL model_count: got %0d want %0d", count, n);
        end
        checks++;
        if (req_valid !== (n > 0)) begin
            errors++; $display("FAIL model_valid: got %0b want %0b", req_valid, n > 0);
        end
        checks++;
        if (acc_stall !== exp_stall) begin
            errors++; $display("FAIL model_stall: got %0b want %0b", acc_stall, exp_stall);
        end
        if (n > 0) begin
            head = sb[0];
            checks++;
            if ({req_addr, req_we} !== head) begin
                errors++;
                $display("FAIL model_head: got %h/%0b want %h/%0b",
                         req_addr, req_we, head[32:1], head[0]);
            end
        end
        if (rst) begin
            sb.delete();
        end else begin
            if (mrg) sb[n-1][0] = sb[n-1][0] | acc_we;
            if (pp) begin
                void'(sb.pop_front());
                pops++;
            end
            if (psh) sb.push_back({acc_addr[31:LB], {LB{1'b0}}, acc_we});
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic access(input logic [31:0] a, input logic we);
        acc_valid = 1'b1; hit = 1'b1; acc_addr = a; acc_we = we;
        cyc();
        acc_valid = 1'b0; hit = 1'b0;
    endtask

    task automatic drain();
        req_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (count == 0) break;
        end
        checks++;
        if (count !== 3'd0) begin
            errors++; $display("FAIL drain_timeout: count %0d want 0", count);
        end
        cyc();
        req_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; acc_valid = 0; acc_we = 0; hit = 0; acc_addr = 0; req_ready = 0;
        cyc(); cyc();
        @(negedge clk);
        checks++;
        if ({req_valid, req_addr, req_we, count, acc_stall} !== 38'h0) begin
            errors++;
            $display("FAIL reset_vals: v=%0b a=%h we=%0b c=%0d st=%0b want all 0",
                     req_valid, req_addr, req_we, count, acc_stall);
        end
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_single();
        access(32'h0000_1234, 1'b1);
        @(negedge clk);
        checks++;
        if ({req_valid, req_addr, req_we, count} !== {1'b1, 32'h0000_1230, 1'b1, 3'd1}) begin
            errors++;
            $display("FAIL single: v=%0b a=%h we=%0b c=%0d want 1/00001230/1/1",
                     req_valid, req_addr, req_we, count);
        end
        drain();
    endtask

    task automatic test_miss();
        for (int i = 0; i < 10; i++) begin
            acc_valid = 1'b1; hit = 1'b0; acc_addr = $urandom; acc_we = 1'($urandom);
            @(negedge clk);
            checks++;
            if (req_valid !== 1'b0 || count !== 3'd0) begin
                errors++; $display("FAIL miss: v=%0b c=%0d want 0/0", req_valid, count);
            end
            cyc();
        end
        acc_valid = 1'b0;
    endtask

    task automatic test_fill_stall();
        for (int i = 1; i <= 4; i++) access(32'(i) * 32'h100, 1'b0);
        acc_valid = 1'b1; hit = 1'b1; acc_addr = 32'h500; acc_we = 1'b1;
        @(negedge clk);
        checks++;
        if (acc_stall !== 1'b1 || count !== 3'd4) begin
            errors++; $display("FAIL full_stall: st=%0b c=%0d want 1/4", acc_stall, count);
        end
        cyc();
        req_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (acc_stall !== 1'b1) begin
            errors++; $display("FAIL stall_on_pop: st=%0b want 1", acc_stall);
        end
        cyc();
        req_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (acc_stall !== 1'b0 || count !== 3'd3) begin
            errors++; $display("FAIL after_pop: st=%0b c=%0d want 0/3", acc_stall, count);
        end
        cyc();
        acc_valid = 1'b0; hit = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 3'd4) begin
            errors++; $display("FAIL refill: c=%0d want 4", count);
        end
        drain();
    endtask

    task automatic test_wrap();
        int p0;
        p0 = pops;
        req_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            acc_valid = 1'b1; hit = 1'b1; acc_addr = 32'h2000 + 32'(i) * 32'h40; acc_we = 1'(i);
            @(negedge clk);
            checks++;
            if (count > 3'd1) begin
                errors++; $display("FAIL wrap_count: c=%0d want <=1", count);
            end
            cyc();
        end
        acc_valid = 1'b0; hit = 1'b0;
        drain();
        checks++;
        if (pops - p0 !== 9) begin
            errors++; $display("FAIL wrap_pops: got %0d want 9", pops - p0);
        end
    endtask

    task automatic test_merge();
        for (int i = 1; i <= 4; i++) access(32'(i) * 32'h100, 1'b0);
        acc_valid = 1'b1; hit = 1'b1; acc_addr = 32'h408; acc_we = 1'b1;
        @(negedge clk);
        checks++;
`ifdef SMC_LINE_MERGE_EN
        if (acc_stall !== 1'b0 || count !== 3'd4) begin
            errors++; $display("FAIL merge_full: st=%0b c=%0d want 0/4", acc_stall, count);
        end
        cyc();
        acc_valid = 1'b0; hit = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 3'd4) begin
            errors++; $display("FAIL merge_count: c=%0d want 4", count);
        end
`else
        if (acc_stall !== 1'b1) begin
            errors++; $display("FAIL nomerge_stall: st=%0b want 1", acc_stall);
        end
        cyc();
        acc_valid = 1'b0; hit = 1'b0;
`endif
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) access(32'h3000 + 32'(i) * 32'h10, 1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 3'd0 || req_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid: c=%0d v=%0b want 0/0", count, req_valid);
        end
        cyc();
        access(32'h4567, 1'b0);
        @(negedge clk);
        checks++;
        if ({req_valid, req_addr, req_we, count} !== {1'b1, 32'h0000_4560, 1'b0, 3'd1}) begin
            errors++;
            $display("FAIL post_reset_push: v=%0b a=%h we=%0b c=%0d want 1/00004560/0/1",
                     req_valid, req_addr, req_we, count);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_miss();
        test_fill_stall();
        test_wrap();
        test_merge();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
